// File: rtl/uvbot_scan_ctrl_if.sv
// rtl/uvbot_scan_ctrl_if.sv - sample-memory read port and beat stream of the scan sequencer (UVBOT_LONLAT_EN adds coordinates)
interface uvbot_scan_ctrl_if #(
  parameter int NX_W   = 10,
  parameter int NY_W   = 10,
  parameter int REC_W  = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 28
`ifdef UVBOT_LONLAT_EN
  ,
  parameter int COORD_W = 24
`endif
) ();

  // sample memory read port
  logic                rd_req;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_ack;
  logic [DATA_W-1:0]   rd_data;

  // per-cell output beat
  logic                out_valid;
  logic                out_ready;
  logic [NX_W-1:0]     out_i;
  logic [NY_W-1:0]     out_j;
  logic [REC_W-1:0]    out_rec;
  logic [DATA_W-1:0]   out_u;
  logic [DATA_W-1:0]   out_v;
  logic [2*DATA_W:0]   out_sq;
`ifdef UVBOT_LONLAT_EN
  logic [COORD_W-1:0]  out_lon;
  logic [COORD_W-1:0]  out_lat;
`endif

  modport master (
    output rd_req, rd_addr,
    input  rd_ack, rd_data,
    output out_valid,
    input  out_ready,
    output out_i, out_j, out_rec, out_u, out_v, out_sq
`ifdef UVBOT_LONLAT_EN
    ,
    output out_lon, out_lat
`endif
  );

  modport slave (
    input  rd_req, rd_addr,
    output rd_ack, rd_data,
    input  out_valid,
    output out_ready,
    input  out_i, out_j, out_rec, out_u, out_v, out_sq
`ifdef UVBOT_LONLAT_EN
    ,
    input  out_lon, out_lat
`endif
  );

endinterface

// File: rtl/uvbot_scan_ctrl.sv
// rtl/uvbot_scan_ctrl.sv - raster scan sequencer fetching ubot/vbot per cell and emitting (i,j,rec,u,v,u^2+v^2) beats; optional UVBOT_LONLAT_EN
module uvbot_scan_ctrl #(
  parameter int NX_W    = 10,
  parameter int NY_W    = 10,
  parameter int REC_W   = 8,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 28,
  parameter int COORD_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NX_W-1:0]     cfg_nx,
  input  logic [NY_W-1:0]     cfg_ny,
  input  logic [REC_W-1:0]    cfg_nrecs,
  input  logic [ADDR_W-1:0]   cfg_vbase,
`ifdef UVBOT_LONLAT_EN
  input  logic [COORD_W-1:0]  cfg_lon0,
  input  logic [COORD_W-1:0]  cfg_lat0,
  input  logic [COORD_W-1:0]  cfg_dlon,
  input  logic [COORD_W-1:0]  cfg_dlat,
`endif
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  uvbot_scan_ctrl_if.master   bus
);

  localparam int SQ_W = 2*DATA_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_U,
    S_RD_V,
    S_EMIT,
    S_FIN
  } state_t;

  state_t              state;
  logic [NX_W-1:0]     nx_r;
  logic [NY_W-1:0]     ny_r;
  logic [REC_W-1:0]    nrecs_r;
  logic [ADDR_W-1:0]   vbase_r;
  logic [NX_W-1:0]     i_r;
  logic [NY_W-1:0]     j_r;
  logic [REC_W-1:0]    rec_r;
  logic [ADDR_W-1:0]   lin_r;
  logic [DATA_W-1:0]   u_r;
  logic [DATA_W-1:0]   v_r;
  logic [SQ_W-1:0]     sq_r;
  logic                err_flag;
  logic                rd_req_r;
  logic [ADDR_W-1:0]   rd_addr_r;
  logic                out_valid_r;

  logic accept;
  logic take;
  logic last_i;
  logic last_j;
  logic last_rec;
  logic cfg_zero;

  // Sign-extend to the full result width so the most negative sample squares correctly.
  function automatic logic [SQ_W-1:0] square(input logic [DATA_W-1:0] d);
    logic signed [SQ_W-1:0] e;
    e = {{(SQ_W-DATA_W){d[DATA_W-1]}}, d};
    return SQ_W'(e * e);
  endfunction

  assign accept   = (state == S_IDLE) && start;
  assign take     = (state == S_EMIT) && bus.out_ready;
  assign last_i   = (i_r == nx_r - NX_W'(1));
  assign last_j   = (j_r == ny_r - NY_W'(1));
  assign last_rec = (rec_r == nrecs_r - REC_W'(1));
  assign cfg_zero = (cfg_nx == '0) || (cfg_ny == '0) || (cfg_nrecs == '0);

  // Scan FSM: config latch, two-read fetch per cell, beat hold under backpressure, one-cycle done
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      nx_r        <= '0;
      ny_r        <= '0;
      nrecs_r     <= '0;
      vbase_r     <= '0;
      i_r         <= '0;
      j_r         <= '0;
      rec_r       <= '0;
      lin_r       <= '0;
      u_r         <= '0;
      v_r         <= '0;
      sq_r        <= '0;
      err_flag    <= 1'b0;
      rd_req_r    <= 1'b0;
      rd_addr_r   <= '0;
      out_valid_r <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            nx_r    <= cfg_nx;
            ny_r    <= cfg_ny;
            nrecs_r <= cfg_nrecs;
            vbase_r <= cfg_vbase;
            i_r     <= '0;
            j_r     <= '0;
            rec_r   <= '0;
            lin_r   <= '0;
            busy    <= 1'b1;
            if (cfg_zero) begin
              err_flag <= 1'b1;
              state    <= S_FIN;
            end else begin
              err_flag  <= 1'b0;
              rd_req_r  <= 1'b1;
              rd_addr_r <= '0;
              state     <= S_RD_U;
            end
          end
        end
        S_RD_U: begin
          if (bus.rd_ack) begin
            u_r       <= bus.rd_data;
            rd_addr_r <= lin_r + vbase_r;
            state     <= S_RD_V;
          end
        end
        S_RD_V: begin
          if (bus.rd_ack) begin
            v_r         <= bus.rd_data;
            sq_r        <= square(u_r) + square(bus.rd_data);
            rd_req_r    <= 1'b0;
            out_valid_r <= 1'b1;
            state       <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (take) begin
            out_valid_r <= 1'b0;
            if (last_i) begin
              i_r <= '0;
              if (last_j) begin
                j_r   <= '0;
                rec_r <= rec_r + REC_W'(1);
              end else begin
                j_r <= j_r + NY_W'(1);
              end
            end else begin
              i_r <= i_r + NX_W'(1);
            end
            if (last_i && last_j && last_rec) begin
              state <= S_FIN;
            end else begin
              lin_r     <= lin_r + ADDR_W'(1);
              rd_addr_r <= lin_r + ADDR_W'(1);
              rd_req_r  <= 1'b1;
              state     <= S_RD_U;
            end
          end
        end
        S_FIN: begin
          done    <= 1'b1;
          cfg_err <= err_flag;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_req    = rd_req_r;
  assign bus.rd_addr   = rd_addr_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_i     = i_r;
  assign bus.out_j     = j_r;
  assign bus.out_rec   = rec_r;
  assign bus.out_u     = u_r;
  assign bus.out_v     = v_r;
  assign bus.out_sq    = sq_r;

  // The linear index must address a whole field without aliasing; this block only exists for bad widths.
  if (ADDR_W < NX_W + NY_W + REC_W) begin : g_addr_w_too_narrow
  end

`ifdef UVBOT_LONLAT_EN
  logic [COORD_W-1:0] lon0_r;
  logic [COORD_W-1:0] lat0_r;
  logic [COORD_W-1:0] dlon_r;
  logic [COORD_W-1:0] dlat_r;
  logic [COORD_W-1:0] lon_r;
  logic [COORD_W-1:0] lat_r;

  // Coordinates accumulate alongside the counters: lon restarts each row, lat restarts each record
  always_ff @(posedge clk) begin
    if (rst) begin
      lon0_r <= '0;
      lat0_r <= '0;
      dlon_r <= '0;
      dlat_r <= '0;
      lon_r  <= '0;
      lat_r  <= '0;
    end else if (accept) begin
      lon0_r <= cfg_lon0;
      lat0_r <= cfg_lat0;
      dlon_r <= cfg_dlon;
      dlat_r <= cfg_dlat;
      lon_r  <= cfg_lon0;
      lat_r  <= cfg_lat0;
    end else if (take) begin
      if (last_i) begin
        lon_r <= lon0_r;
        lat_r <= last_j ? lat0_r : lat_r + dlat_r;
      end else begin
        lon_r <= lon_r + dlon_r;
      end
    end
  end

  assign bus.out_lon = lon_r;
  assign bus.out_lat = lat_r;
`else
  // Coordinate width only matters when the lon/lat feature is built in.
  if (COORD_W < 1) begin : g_coord_w_invalid
  end
`endif

endmodule

// File: tb/tb_uvbot_scan_ctrl.sv
// tb/tb_uvbot_scan_ctrl.sv - randomized self-checking bench for uvbot_scan_ctrl against a raster-order reference model
module tb_uvbot_scan_ctrl;

  localparam int NX_W    = 10;
  localparam int NY_W    = 10;
  localparam int REC_W   = 8;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 28;
  localparam int COORD_W = 24;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [NX_W-1:0]     cfg_nx;
  logic [NY_W-1:0]     cfg_ny;
  logic [REC_W-1:0]    cfg_nrecs;
  logic [ADDR_W-1:0]   cfg_vbase;
  logic                busy;
  logic                done;
  logic                cfg_err;
`ifdef UVBOT_LONLAT_EN
  logic [COORD_W-1:0]  cfg_lon0;
  logic [COORD_W-1:0]  cfg_lat0;
  logic [COORD_W-1:0]  cfg_dlon;
  logic [COORD_W-1:0]  cfg_dlat;
  int                  g_lon0 = 0;
  int                  g_lat0 = 0;
  int                  g_dlon = 0;
  int                  g_dlat = 0;
`endif

  uvbot_scan_ctrl_if #(
    .NX_W(NX_W), .NY_W(NY_W), .REC_W(REC_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
`ifdef UVBOT_LONLAT_EN
    , .COORD_W(COORD_W)
`endif
  ) bus ();

  uvbot_scan_ctrl #(
    .NX_W(NX_W), .NY_W(NY_W), .REC_W(REC_W), .DATA_W(DATA_W),
    .ADDR_W(ADDR_W), .COORD_W(COORD_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_nx    (cfg_nx),
    .cfg_ny    (cfg_ny),
    .cfg_nrecs (cfg_nrecs),
    .cfg_vbase (cfg_vbase),
`ifdef UVBOT_LONLAT_EN
    .cfg_lon0  (cfg_lon0),
    .cfg_lat0  (cfg_lat0),
    .cfg_dlon  (cfg_dlon),
    .cfg_dlat  (cfg_dlat),
`endif
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NX_W-1:0]    i;
    logic [NY_W-1:0]    j;
    logic [REC_W-1:0]   rec;
    logic [DATA_W-1:0]  u;
    logic [DATA_W-1:0]  v;
    logic [2*DATA_W:0]  sq;
    logic [COORD_W-1:0] lon;
    logic [COORD_W-1:0] lat;
  } beat_t;

  beat_t             exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  int                checks = 0;
  int                errors = 0;
  int                mem_mode = 0;
  logic [15:0]       mem_seed = 16'h1234;

  // Memory contents: hashed per address, or the fixed patterns the directed cases need
  function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
    logic [31:0] h;
    if (mem_mode == 1) return (a < 28'h100) ? 16'd3 : 16'd4;
    if (mem_mode == 2) return 16'h8000;
    h = ({4'b0, a} * 32'h9E3779B1) ^ {16'h0, mem_seed};
    return h[31:16];
  endfunction

  function automatic int pick_delay(input int d);
    if (d < 0) return -d;
    return int'($urandom_range(d, 0));
  endfunction

  // Reference: enumerate cells rec-major, j, then i; address = flat index, v plane offset by vbase
  task automatic build_model(input int nx, input int ny, input int nrecs, input logic [ADDR_W-1:0] vbase);
    beat_t b;
    logic [ADDR_W-1:0] au;
    logic [ADDR_W-1:0] av;
    longint su;
    longint sv;
    for (int r = 0; r < nrecs; r++)
      for (int y = 0; y < ny; y++)
        for (int x = 0; x < nx; x++) begin
          au = ADDR_W'((r*ny + y)*nx + x);
          av = au + vbase;
          addr_q.push_back(au);
          addr_q.push_back(av);
          b.i   = NX_W'(x);
          b.j   = NY_W'(y);
          b.rec = REC_W'(r);
          b.u   = mem_val(au);
          b.v   = mem_val(av);
          su    = longint'($signed(b.u));
          sv    = longint'($signed(b.v));
          b.sq  = (2*DATA_W+1)'(su*su + sv*sv);
          b.lon = '0;
          b.lat = '0;
`ifdef UVBOT_LONLAT_EN
          b.lon = COORD_W'(g_lon0 + x*g_dlon);
          b.lat = COORD_W'(g_lat0 + y*g_dlat);
`endif
          exp_q.push_back(b);
        end
  endtask

  // One scan: start pulse, reactive memory and sink, per-cycle comparison against the model
  task automatic run_scan(input int nx, input int ny, input int nrecs, input logic [ADDR_W-1:0] vbase,
                          input int delay, input int ready_pct, input int abort_at, input bit check_timing);
    int    cyc;
    int    delay_cnt;
    int    cur_delay;
    int    emit_cnt;
    bit    ack_pend;
    bit    hs_pend;
    bit    zero;
    bit    finished;
    bit    aborted;
    bit    hold;
    beat_t snap;
    zero = (nx == 0) || (ny == 0) || (nrecs == 0);
    exp_q.delete();
    addr_q.delete();
    if (!zero) build_model(nx, ny, nrecs, vbase);
    cur_delay = pick_delay(delay);
    delay_cnt = 0;
    emit_cnt  = 0;
    ack_pend  = 0;
    hs_pend   = 0;
    hold      = 0;
    finished  = 0;
    aborted   = 0;
    snap      = '{default: '0};
    @(negedge clk);
    cfg_nx    = NX_W'(nx);
    cfg_ny    = NY_W'(ny);
    cfg_nrecs = REC_W'(nrecs);
    cfg_vbase = vbase;
`ifdef UVBOT_LONLAT_EN
    cfg_lon0  = COORD_W'(g_lon0);
    cfg_lat0  = COORD_W'(g_lat0);
    cfg_dlon  = COORD_W'(g_dlon);
    cfg_dlat  = COORD_W'(g_dlat);
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!finished && cyc < 20000) begin
      if (ack_pend) void'(addr_q.pop_front());
      if (hs_pend)  void'(exp_q.pop_front());
      ack_pend = 0;
      hs_pend  = 0;
      if (cyc == 1) begin
        checks++;
        if (bus.rd_req !== !zero) begin
          errors++;
          $display("FAIL first_rd_req: got %0b expected %0b", bus.rd_req, !zero);
        end
      end
      if (bus.rd_req) begin
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL rd_extra: got rd_req with addr %0h expected no request", bus.rd_addr);
        end else if (bus.rd_addr !== addr_q[0]) begin
          errors++;
          $display("FAIL rd_addr: got %0h expected %0h", bus.rd_addr, addr_q[0]);
        end
      end
      if (hold) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.rd_req !== 1'b0 || bus.out_u !== snap.u ||
            bus.out_v !== snap.v || bus.out_sq !== snap.sq || bus.out_i !== snap.i) begin
          errors++;
          $display("FAIL hold: got valid=%0b rd_req=%0b u=%0h v=%0h expected valid=1 rd_req=0 u=%0h v=%0h",
                   bus.out_valid, bus.rd_req, bus.out_u, bus.out_v, snap.u, snap.v);
        end
      end
      if (bus.out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_extra: got beat i=%0d j=%0d expected none", bus.out_i, bus.out_j);
        end else if (bus.out_i !== exp_q[0].i || bus.out_j !== exp_q[0].j || bus.out_rec !== exp_q[0].rec ||
                     bus.out_u !== exp_q[0].u || bus.out_v !== exp_q[0].v || bus.out_sq !== exp_q[0].sq ||
                     bus.rd_req !== 1'b0) begin
          errors++;
          $display("FAIL beat: got i=%0d j=%0d rec=%0d u=%0h v=%0h sq=%0h rd_req=%0b expected i=%0d j=%0d rec=%0d u=%0h v=%0h sq=%0h rd_req=0",
                   bus.out_i, bus.out_j, bus.out_rec, bus.out_u, bus.out_v, bus.out_sq, bus.rd_req,
                   exp_q[0].i, exp_q[0].j, exp_q[0].rec, exp_q[0].u, exp_q[0].v, exp_q[0].sq);
        end
`ifdef UVBOT_LONLAT_EN
        checks++;
        if (exp_q.size() != 0 && (bus.out_lon !== exp_q[0].lon || bus.out_lat !== exp_q[0].lat)) begin
          errors++;
          $display("FAIL coord: got lon=%0h lat=%0h expected lon=%0h lat=%0h",
                   bus.out_lon, bus.out_lat, exp_q[0].lon, exp_q[0].lat);
        end
`endif
      end
      if (done) begin
        finished = 1;
        checks++;
        if (cfg_err !== zero || exp_q.size() != 0 || addr_q.size() != 0) begin
          errors++;
          $display("FAIL done_end: got cfg_err=%0b beats_left=%0d reads_left=%0d expected cfg_err=%0b 0 0",
                   cfg_err, exp_q.size(), addr_q.size(), zero);
        end
        if (zero || check_timing) begin
          checks++;
          if (cyc != (zero ? 2 : 3*nx*ny*nrecs + 2)) begin
            errors++;
            $display("FAIL done_cycle: got %0d expected %0d", cyc, zero ? 2 : 3*nx*ny*nrecs + 2);
          end
        end
      end else begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy: got %0b expected 1 at cycle %0d", busy, cyc);
        end
      end
      if (!finished && abort_at != 0 && cyc == abort_at) begin
        finished = 1;
        aborted  = 1;
        rst      = 1'b1;
        start    = 1'b0;
        bus.rd_ack    = 1'b0;
        bus.out_ready = 1'b0;
      end
      if (!finished) begin
        start     = ($urandom_range(9, 0) == 0);
        cfg_nx    = NX_W'($urandom);
        cfg_ny    = NY_W'($urandom);
        cfg_nrecs = REC_W'($urandom);
        cfg_vbase = ADDR_W'($urandom);
        bus.rd_data = DATA_W'($urandom);
        if (bus.rd_req) begin
          if (delay_cnt >= cur_delay) begin
            bus.rd_ack  = 1'b1;
            bus.rd_data = mem_val(bus.rd_addr);
            ack_pend    = 1;
            delay_cnt   = 0;
            cur_delay   = pick_delay(delay);
          end else begin
            bus.rd_ack = 1'b0;
            delay_cnt++;
          end
        end else begin
          bus.rd_ack = ($urandom_range(7, 0) == 0);
        end
        if (bus.out_valid) emit_cnt++;
        else emit_cnt = 0;
        if (ready_pct < 0) bus.out_ready = (emit_cnt >= 6);
        else bus.out_ready = (int'($urandom_range(99, 0)) < ready_pct);
        hs_pend = bus.out_valid && bus.out_ready;
        hold    = bus.out_valid && !bus.out_ready;
        snap.u  = bus.out_u;
        snap.v  = bus.out_v;
        snap.sq = bus.out_sq;
        snap.i  = bus.out_i;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    if (!finished) begin
      errors++;
      $display("FAIL timeout: got no done after %0d cycles expected done", cyc);
    end
    if (!aborted) begin
      bus.rd_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || cfg_err !== 1'b0 || busy !== 1'b0 || bus.rd_req !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL after_done: got done=%0b err=%0b busy=%0b rd_req=%0b valid=%0b expected all 0",
                 done, cfg_err, busy, bus.rd_req, bus.out_valid);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [127:0] obs;
    obs = {busy, done, cfg_err, bus.rd_req, bus.rd_addr, bus.out_valid, bus.out_i, bus.out_j,
           bus.out_rec, bus.out_u, bus.out_v, bus.out_sq};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL %s: got %0h expected 0", name, obs);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    cfg_nx = '0; cfg_ny = '0; cfg_nrecs = '0; cfg_vbase = '0;
`ifdef UVBOT_LONLAT_EN
    cfg_lon0 = '0; cfg_lat0 = '0; cfg_dlon = '0; cfg_dlat = '0;
`endif
    bus.rd_ack = 1'b0;
    bus.rd_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_scan_order;
    mem_mode = 1;
    run_scan(2, 2, 1, 28'h100, 0, 100, 0, 1);
  endtask

  task automatic test_signed_square;
    mem_mode = 2;
    run_scan(3, 1, 2, 28'h40, 0, 100, 0, 1);
  endtask

  task automatic test_backpressure;
    mem_mode = 0;
    mem_seed = 16'hBEEF;
    run_scan(2, 2, 2, 28'h200, 1, -1, 0, 0);
  endtask

  task automatic test_mem_stall;
    mem_mode = 0;
    mem_seed = 16'h0F0F;
    run_scan(3, 2, 1, 28'h1000, -4, 100, 0, 0);
  endtask

  task automatic test_zero_config;
    run_scan(3, 0, 2, 28'h10, 0, 100, 0, 0);
    run_scan(0, 2, 2, 28'h10, 0, 100, 0, 0);
    run_scan(2, 2, 0, 28'h10, 0, 100, 0, 0);
  endtask

  task automatic test_random;
    mem_mode = 0;
    for (int n = 0; n < 6; n++) begin
      mem_seed = 16'($urandom);
      run_scan(int'($urandom_range(5, 1)), int'($urandom_range(4, 1)), int'($urandom_range(3, 1)),
               ADDR_W'($urandom), 3, 60, 0, 0);
    end
  endtask

  task automatic test_abort_restart;
    mem_mode = 0;
    mem_seed = 16'h5A5A;
    run_scan(3, 2, 2, 28'h40, 1, 70, 9, 0);
    @(negedge clk);
    check_all_zero("abort_clear");
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || bus.rd_req !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet: got done=%0b rd_req=%0b busy=%0b expected 0 0 0", done, bus.rd_req, busy);
      end
    end
    run_scan(3, 2, 2, 28'h40, 1, 70, 0, 0);
  endtask

`ifdef UVBOT_LONLAT_EN
  task automatic test_coords;
    mem_mode = 0;
    g_lon0 = -100; g_dlon = 10;
    g_lat0 = 50;   g_dlat = -7;
    run_scan(3, 2, 2, 28'h80, 0, 80, 0, 0);
  endtask
`endif

  initial begin
    test_reset;
    test_scan_order;
    test_signed_square;
    test_backpressure;
    test_mem_stall;
    test_zero_config;
    test_random;
    test_abort_restart;
`ifdef UVBOT_LONLAT_EN
    test_coords;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
